uart_tx_buffered: RTL

//  Buffered UART transmitter: accepts bytes through a valid/ready handshake into a FIFO
//  and serializes each byte as 8N1 on o_UART_TX, LSB first.

---
 rtl/uart_tx_buffered.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: valid/ready byte FIFO feeding a serializer.
// Define UART_TX_PARITY_EN to insert a parity bit (8E1/8O1 via PARITY_ODD).
module uart_tx_buffered #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_AW      = 4,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic               i_Clk,
  input  logic               i_Rst_n,
  input  logic               i_TX_DV,
  input  logic [7:0]         i_TX_Byte,
  output logic               o_TX_Ready,
  output logic [FIFO_AW:0]   o_FIFO_Count,
  output logic               o_TX_Active,
  output logic               o_TX_Done,
  output logic               o_Overflow,
  output logic               o_UART_TX
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int TW =
    (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] T_LAST =
    TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_ONE = TW'(1);
  localparam logic [FIFO_AW:0] P_ONE =
    (FIFO_AW + 1)'(1);

`ifdef UART_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic [7:0]       mem [DEPTH];
  logic [FIFO_AW:0] wr_ptr;
  logic [FIFO_AW:0] rd_ptr;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             ovf_q;

  state_t           state_q;
  state_t           state_d;
  logic [TW-1:0]    timer_q;
  logic [TW-1:0]    timer_d;
  logic [2:0]       idx_q;
  logic [2:0]       idx_d;
  logic [7:0]       shift_q;
  logic             bit_done;
  logic             line_q;
  logic             line_d;
  logic             active_q;
  logic             active_d;

  // Same-MSB / equal-index means empty, differing MSB means full.
  assign empty = (wr_ptr == rd_ptr);
  assign full  =
    (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
    (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign push  = i_TX_DV & ~full;

  assign o_TX_Ready   = ~full;
  assign o_FIFO_Count = wr_ptr - rd_ptr;
  assign o_Overflow   = ovf_q;

  always_ff @(posedge i_Clk) begin
    if (push) begin
      mem[wr_ptr[FIFO_AW-1:0]] <= i_TX_Byte;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + P_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + P_ONE;
      end
      if (i_TX_DV && full) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign bit_done = (timer_q == T_LAST);

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      line_q   <= 1'b1;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      idx_q    <= idx_d;
      line_q   <= line_d;
      active_q <= active_d;
      if (pop) begin
        shift_q <= mem[rd_ptr[FIFO_AW-1:0]];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q + T_ONE;
    idx_d   = idx_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_done) begin
          timer_d = '0;
          idx_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_done) begin
          timer_d = '0;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = PAR_EN ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (bit_done) begin
          timer_d = '0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_done) begin
          timer_d = '0;
          // Back-to-back frames: no idle bit between stop and start.
          if (!empty) begin
            pop     = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        timer_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Line and active are registered from the next state.
  always_comb begin
    line_d = 1'b1;
    unique case (1'b1)
      (state_d == S_START):  line_d = 1'b0;
      (state_d == S_DATA):   line_d = shift_q[idx_d];
      (state_d == S_PARITY): line_d = ^shift_q ^ PARITY_ODD;
      default:               line_d = 1'b1;
    endcase
    active_d = (state_d != S_IDLE);
  end

  assign o_UART_TX   = line_q;
  assign o_TX_Active = active_q;
  assign o_TX_Done   = (state_q == S_STOP) && bit_done;

endmodule
